// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline stall/flush sequencing (load-use, redirect, data-memory wait).
// Optional macro HAZARD_PERF_CNT_EN adds stall/flush cycle counters.
module pipe_hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_redirect,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_stall,
    output logic              memwb_flush,
    output logic              mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       load_use, timeout_hit;
    logic       pc_stall_d, ifid_stall_d, ifid_flush_d, idex_flush_d;
    logic       exmem_stall_d, memwb_flush_d, mem_timeout_d;

    assign load_use    = ex_is_load && ex_rd != '0 &&
                         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    assign timeout_hit = wait_cnt_q == 8'(MEM_TIMEOUT);

    // Hazard decode: memory wait outranks redirect, which outranks load-use.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        pc_stall_d    = 1'b0;
        ifid_stall_d  = 1'b0;
        ifid_flush_d  = 1'b0;
        idex_flush_d  = 1'b0;
        exmem_stall_d = 1'b0;
        memwb_flush_d = 1'b0;
        mem_timeout_d = 1'b0;
        if (state_q == MEM_WAIT) begin
            if (mem_ready || timeout_hit) begin
                mem_timeout_d = !mem_ready;
                state_d       = RUN;
                wait_cnt_d    = 8'd0;
            end else begin
                pc_stall_d    = 1'b1;
                ifid_stall_d  = 1'b1;
                exmem_stall_d = 1'b1;
                memwb_flush_d = 1'b1;
                wait_cnt_d    = wait_cnt_q == 8'hFF ? wait_cnt_q : wait_cnt_q + 8'd1;
            end
        end else if (mem_req && !mem_ready) begin
            pc_stall_d    = 1'b1;
            ifid_stall_d  = 1'b1;
            exmem_stall_d = 1'b1;
            memwb_flush_d = 1'b1;
            state_d       = MEM_WAIT;
            wait_cnt_d    = 8'd1;
        end else if (ex_redirect) begin
            ifid_flush_d = 1'b1;
            idex_flush_d = 1'b1;
        end else if (load_use) begin
            pc_stall_d   = 1'b1;
            ifid_stall_d = 1'b1;
            idex_flush_d = 1'b1;
        end
    end

    // Outputs are forced low while reset is held so the pipeline sees no strobes.
    assign pc_stall    = pc_stall_d    & rst_n;
    assign ifid_stall  = ifid_stall_d  & rst_n;
    assign ifid_flush  = ifid_flush_d  & rst_n;
    assign idex_flush  = idex_flush_d  & rst_n;
    assign exmem_stall = exmem_stall_d & rst_n;
    assign memwb_flush = memwb_flush_d & rst_n;
    assign mem_timeout = mem_timeout_d & rst_n;

    // State and wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Cycle counters for PC stalls and IF/ID flushes; wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= 32'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            perf_stall_cnt <= perf_stall_cnt + {31'd0, pc_stall};
            perf_flush_cnt <= perf_flush_cnt + {31'd0, ifid_flush};
        end
    end
`endif

endmodule
